// File: rtl/serial_divider_ctrl.sv
// Sequencer for an unsigned restoring shift-subtract divider.
// One quotient bit per clock. Results are held on the outputs until the next
// completion or reset. Divide-by-zero completes in a single cycle with a
// defined result, and an abort drops the running operation silently.
module serial_divider_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            dbz_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CNTW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] dvd_q, dsr_q, rem_q, quo_q;
    logic [CNTW-1:0] cnt_q;

    logic [XLEN:0]   trial, diff;
    logic            take;
    logic [XLEN-1:0] rem_next, quo_next;
    logic            accept, step, last;

    // One restoring step. The compare is XLEN+1 bits wide so that divisors
    // above 2^(XLEN-1) cannot overflow the trial subtraction.
    always_comb begin
        trial    = {rem_q, dvd_q[XLEN-1]};
        diff     = trial - {1'b0, dsr_q};
        take     = (trial >= {1'b0, dsr_q});
        rem_next = take ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], take};
    end

    // Next-state logic. Start is honoured in IDLE and DONE only, and abort
    // takes priority over the iteration step in RUN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = (divisor_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == '0) begin
                        last    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Working registers. They are loaded on accept and advanced once per RUN cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (accept && divisor_i != '0) begin
            dvd_q <= dividend_i;
            dsr_q <= divisor_i;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CNTW'(XLEN - 1);
        end else if (step) begin
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    // Result registers. They change only on the edge that enters DONE.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            quotient_o  <= '0;
            remainder_o <= '0;
            dbz_o       <= 1'b0;
        end else if (accept && divisor_i == '0) begin
            quotient_o  <= '1;
            remainder_o <= dividend_i;
            dbz_o       <= 1'b1;
        end else if (last) begin
            quotient_o  <= quo_next;
            remainder_o <= rem_next;
            dbz_o       <= 1'b0;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_divider_ctrl.sv
// Directed and random checks of serial_divider_ctrl against plain / and %.
module tb_serial_divider_ctrl;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_ni, start_i, abort_i;
    logic [XLEN-1:0] dividend_i, divisor_i;
    logic            busy_o, done_o, dbz_o;
    logic [XLEN-1:0] quotient_o, remainder_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] prev_q = '0, prev_r = '0;
    logic            prev_dbz = 1'b0;

    serial_divider_ctrl #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy_o(busy_o), .done_o(done_o), .dbz_o(dbz_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a point 1 time unit after a rising edge. Then wait
    // for done_o, or give up after a bound. The task returns in the DONE cycle.
    // A start pulse at cycle junk_at is injected so that RUN must ignore it.
    task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int junk_at);
        logic [XLEN-1:0] eq, er;
        logic            edbz;
        int              lat, k, busy_n;
        edbz = (b == '0);
        eq   = edbz ? '1 : a / b;
        er   = edbz ? a  : a % b;
        lat  = edbz ? 1 : XLEN + 1;
        dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
        k = 1; busy_n = 0;
        while (!done_o && k < 100) begin
            busy_n += int'(busy_o);
            if (k == 16) check("hold_q_mid_run", quotient_o, prev_q);
            if (k == junk_at) begin
                start_i = 1'b1; dividend_i = $urandom; divisor_i = $urandom_range(0, 3);
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            k++;
        end
        check("latency", k, lat);
        check("busy_cycles", busy_n, lat - 1);
        check("busy_in_done", busy_o, 0);
        check("quotient", quotient_o, eq);
        check("remainder", remainder_o, er);
        check("dbz", dbz_o, edbz);
        prev_q = eq; prev_r = er; prev_dbz = edbz;
    endtask

    // Advance one cycle out of DONE and check that the held results did not move.
    task automatic idle_cycle();
        @(posedge clk_i); #1;
        check("done_pulse_1cyc", done_o, 0);
        check("hold_q_idle", quotient_o, prev_q);
        check("hold_r_idle", remainder_o, prev_r);
    endtask

    initial begin
        logic seen_done;
        reset_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        #3;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dbz", dbz_o, 0);
        check("rst_q", quotient_o, 0);
        check("rst_r", remainder_o, 0);
        @(negedge clk_i); reset_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed cases, including wide divisors and quotient=0.
        do_op(100, 7, -1);                 idle_cycle();
        do_op(32'h1234, 0, -1);            idle_cycle();
        do_op(32'hFFFF_FFFF, 1, -1);       idle_cycle();
        do_op(32'hFFFF_FFFF, 32'h8000_0001, -1); idle_cycle();
        do_op(5, 9, -1);                   idle_cycle();

        // Back-to-back: the second start lands in the DONE cycle of the first.
        do_op(100, 7, -1);
        do_op(27, 4, -1);                  idle_cycle();

        // A start pulse during RUN must be ignored.
        do_op(1000, 13, 5);                idle_cycle();

        // Abort at cycle 10. There is no done_o, and the outputs keep their values.
        dividend_i = 32'd99999; divisor_i = 32'd17; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        for (int k = 1; k < 10; k++) begin @(posedge clk_i); #1; end
        abort_i = 1'b1;
        @(posedge clk_i); #1; abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            seen_done |= done_o;
            @(posedge clk_i); #1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_hold_q", quotient_o, prev_q);
        check("abort_hold_r", remainder_o, prev_r);
        check("abort_hold_dbz", dbz_o, prev_dbz);

        // An abort in IDLE has no effect.
        abort_i = 1'b1; @(posedge clk_i); #1; abort_i = 1'b0;
        check("abort_idle_busy", busy_o, 0);
        do_op(50, 6, -1);                  idle_cycle();

        // Asynchronous reset between edges, in the middle of RUN.
        dividend_i = 32'hDEAD; divisor_i = 32'h13; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        for (int k = 1; k < 7; k++) begin @(posedge clk_i); #1; end
        #3 reset_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_dbz", dbz_o, 0);
        check("arst_q", quotient_o, 0);
        check("arst_r", remainder_o, 0);
        prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
        @(negedge clk_i); reset_ni = 1'b1;
        @(posedge clk_i); #1;
        do_op(100, 7, -1);                 idle_cycle();

        // Random operands, with some small divisors and divisor zero.
        for (int i = 0; i < 24; i++) begin
            logic [XLEN-1:0] a, b;
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = 32'h8000_0000 | $urandom;
            endcase
            do_op(a, b, -1);
            if (i % 3 == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
